lzc_normalizer: RTL and testbench

Parametrised, pipelined leading-zero counter and normaliser for range renormalisation in the entropy encoder. It accepts an unsigned range word through a valid/ready handshake and returns three results:
- the leading-zero count;
- the left-normalised range;
- a zero flag.

It also keeps a saturating running total of all shifts applied, which the carry/bit-output logic uses for bit accounting. It generalises the fixed 16-bit combinational counter to any width that is a multiple of 4, and adds registered, back-pressurable stages.

---
 rtl/lzc_normalizer.sv | 173 +++++++++++++++++
 tb/tb_lzc_normalizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_normalizer.sv
// Pipelined leading-zero counter and left normaliser with a saturating shift total.
// Define LZC_PIPE_STAGE_EN to register the nibble results ahead of the priority/shift stage.
module lzc_normalizer #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANGE_WIDTH-1:0] in_range,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D_SIZE-1:0]      out_lzc,
  output logic [RANGE_WIDTH-1:0] out_norm,
  output logic                   out_zero,
  input  logic                   clr_total,
  output logic [CNT_WIDTH-1:0]   total_shift
);

  localparam int NIB   = RANGE_WIDTH / 4;
  localparam int SUM_W = ((CNT_WIDTH > D_SIZE) ? CNT_WIDTH : D_SIZE) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  function automatic logic [1:0] nib_count(input logic [3:0] n);
    casez (n)
      4'b1???: nib_count = 2'd0;
      4'b01??: nib_count = 2'd1;
      4'b001?: nib_count = 2'd2;
      default: nib_count = 2'd3;
    endcase
  endfunction

  // Nibble k is counted from the MSB end of the word.
  logic [NIB-1:0]      nib_nz;
  logic [NIB-1:0][1:0] nib_cnt;

  always_comb begin
    for (int k = 0; k < NIB; k++) begin
      nib_nz[k]  = |in_range[RANGE_WIDTH-1-4*k -: 4];
      nib_cnt[k] = nib_count(in_range[RANGE_WIDTH-1-4*k -: 4]);
    end
  end

  logic                   stage2_ready;
  logic                   p_valid;
  logic [RANGE_WIDTH-1:0] p_range;
  logic [NIB-1:0]         p_nz;
  logic [NIB-1:0][1:0]    p_cnt;

  logic                   out_valid_q, out_valid_d;

  assign stage2_ready = !out_valid_q | out_ready;

`ifdef LZC_PIPE_STAGE_EN
  logic                   s1_valid_q, s1_valid_d;
  logic [RANGE_WIDTH-1:0] s1_range_q, s1_range_d;
  logic [NIB-1:0]         s1_nz_q, s1_nz_d;
  logic [NIB-1:0][1:0]    s1_cnt_q, s1_cnt_d;

  assign in_ready = !s1_valid_q | stage2_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_range_d = s1_range_q;
    s1_nz_d    = s1_nz_q;
    s1_cnt_d   = s1_cnt_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_range_d = in_range;
        s1_nz_d    = nib_nz;
        s1_cnt_d   = nib_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_range_q <= '0;
      s1_nz_q    <= '0;
      s1_cnt_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_range_q <= s1_range_d;
      s1_nz_q    <= s1_nz_d;
      s1_cnt_q   <= s1_cnt_d;
    end
  end

  assign p_valid = s1_valid_q;
  assign p_range = s1_range_q;
  assign p_nz    = s1_nz_q;
  assign p_cnt   = s1_cnt_q;
`else
  assign in_ready = stage2_ready;
  assign p_valid  = in_valid;
  assign p_range  = in_range;
  assign p_nz     = nib_nz;
  assign p_cnt    = nib_cnt;
`endif

  // Scanning from the LSB nibble upward lets the most significant non-zero nibble win.
  logic [D_SIZE-1:0]      p_lzc;
  logic [RANGE_WIDTH-1:0] p_norm;
  logic                   p_zero;

  always_comb begin
    p_lzc = D_SIZE'(RANGE_WIDTH);
    for (int k = NIB - 1; k >= 0; k--) begin
      if (p_nz[k]) p_lzc = D_SIZE'(4 * k) + D_SIZE'(p_cnt[k]);
    end
    p_norm = p_range << p_lzc;
    p_zero = ~|p_nz;
  end

  logic [D_SIZE-1:0]      out_lzc_q, out_lzc_d;
  logic [RANGE_WIDTH-1:0] out_norm_q, out_norm_d;
  logic                   out_zero_q, out_zero_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_lzc_d   = out_lzc_q;
    out_norm_d  = out_norm_q;
    out_zero_d  = out_zero_q;
    if (stage2_ready) begin
      out_valid_d = p_valid;
      if (p_valid) begin
        out_lzc_d  = p_lzc;
        out_norm_d = p_norm;
        out_zero_d = p_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_lzc_q   <= '0;
      out_norm_q  <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_lzc_q   <= out_lzc_d;
      out_norm_q  <= out_norm_d;
      out_zero_q  <= out_zero_d;
    end
  end

  // Clear takes effect before the add so a coincident beat still counts.
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [SUM_W-1:0]     total_sum;

  always_comb begin
    total_sum = clr_total ? '0 : SUM_W'(total_q);
    if (out_valid_q && out_ready) total_sum = total_sum + SUM_W'(out_lzc_q);
    total_d = (total_sum > SUM_MAX) ? {CNT_WIDTH{1'b1}} : total_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign out_valid   = out_valid_q;
  assign out_lzc     = out_lzc_q;
  assign out_norm    = out_norm_q;
  assign out_zero    = out_zero_q;
  assign total_shift = total_q;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Bench for lzc_normalizer: 16-bit, 32-bit and 4-bit-total instances share one handshake,
// checked every cycle against an in-order queue model plus directed literal expectations.
module tb_lzc_normalizer;
`ifdef LZC_PIPE_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_total = 1'b0;
  logic [15:0] in_range16 = '0;
  logic [31:0] in_range32 = '0;

  logic        in_ready, out_valid, out_zero;
  logic [4:0]  out_lzc;
  logic [15:0] out_norm;
  logic [23:0] total_shift;

  logic        in_ready_32, out_valid_32, out_zero_32;
  logic [5:0]  out_lzc_32;
  logic [31:0] out_norm_32;
  logic [23:0] total_shift_32;

  logic        in_ready_s, out_valid_s, out_zero_s;
  logic [4:0]  out_lzc_s;
  logic [15:0] out_norm_s;
  logic [3:0]  total_shift_s;

  always #5 clk = ~clk;

  lzc_normalizer #(.RANGE_WIDTH(16), .D_SIZE(5), .CNT_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_range(in_range16), .out_valid(out_valid), .out_ready(out_ready),
    .out_lzc(out_lzc), .out_norm(out_norm), .out_zero(out_zero),
    .clr_total(clr_total), .total_shift(total_shift));

  lzc_normalizer #(.RANGE_WIDTH(32), .D_SIZE(6), .CNT_WIDTH(24)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_range(in_range32), .out_valid(out_valid_32), .out_ready(out_ready),
    .out_lzc(out_lzc_32), .out_norm(out_norm_32), .out_zero(out_zero_32),
    .clr_total(clr_total), .total_shift(total_shift_32));

  lzc_normalizer #(.RANGE_WIDTH(16), .D_SIZE(5), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_range(in_range16), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_lzc(out_lzc_s), .out_norm(out_norm_s), .out_zero(out_zero_s),
    .clr_total(clr_total), .total_shift(total_shift_s));

  typedef struct {
    int          l16;
    logic [15:0] n16;
    bit          z16;
    int          l32;
    logic [31:0] n32;
    bit          z32;
  } exp_t;

  exp_t    q[$];
  longint  exp_tot = 0;
  longint  exp_tot32 = 0;
  longint  exp_sat = 0;
  int      n_vec = 0;
  int      n_err = 0;
  bit      mon_en = 1'b0;

  function automatic int ref_lzc(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) if (v[i]) return w - 1 - i;
    return w;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input longint mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, (q.size() < LAT) || out_ready);
`ifndef LZC_PIPE_STAGE_EN
      chk("out_valid", out_valid, q.size() > 0);
`endif
      chk("total_shift", total_shift, exp_tot);
      chk("total_shift_32", total_shift_32, exp_tot32);
      chk("total_shift_sat", total_shift_s, exp_sat);
      if (out_valid && q.size() == 0) chk("out_valid_empty", out_valid, 0);
      if (out_valid && q.size() > 0) begin
        chk("lzc16", out_lzc, q[0].l16);
        chk("norm16", out_norm, q[0].n16);
        chk("zero16", out_zero, q[0].z16);
        chk("lzc_sat", out_lzc_s, q[0].l16);
        chk("lzc32", out_lzc_32, q[0].l32);
        chk("norm32", out_norm_32, q[0].n32);
        chk("zero32", out_zero_32, q[0].z32);
      end
      if (reset) begin
        q.delete();
        exp_tot = 0; exp_tot32 = 0; exp_sat = 0;
      end else begin
        if (clr_total) begin
          exp_tot = 0; exp_tot32 = 0; exp_sat = 0;
        end
        if (out_valid && out_ready && q.size() > 0) begin
          exp_tot   = sat_add(exp_tot, q[0].l16, 64'hFF_FFFF);
          exp_sat   = sat_add(exp_sat, q[0].l16, 15);
          exp_tot32 = sat_add(exp_tot32, q[0].l32, 64'hFF_FFFF);
          void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e.l16 = ref_lzc({48'd0, in_range16}, 16);
          e.n16 = 16'((32'(in_range16) << e.l16) & 32'hFFFF);
          e.z16 = (in_range16 == 16'd0);
          e.l32 = ref_lzc({32'd0, in_range32}, 32);
          e.n32 = 32'((64'(in_range32) << e.l32) & 64'hFFFF_FFFF);
          e.z32 = (in_range32 == 32'd0);
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lat();
    repeat (LAT - 1) tick();
  endtask

  // Starts aligned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] r16, input logic [31:0] r32);
    bit got = 1'b0;
    in_valid = 1'b1; in_range16 = r16; in_range32 = r32;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", got, 1);
  endtask

  initial begin
    bit got;
    logic [15:0] t16;
    logic [31:0] t32;

    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_lzc", out_lzc, 0);
    chk("rst_out_norm", out_norm, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_total", total_shift, 0);

    tick();
    send(16'h0100, 32'h0100_0000);
    wait_lat();
    @(negedge clk);
    chk("d0100_valid", out_valid, 1);
    chk("d0100_lzc", out_lzc, 7);
    chk("d0100_norm", out_norm, 16'h8000);
    chk("d0100_zero", out_zero, 0);
    chk("d0100_lzc32", out_lzc_32, 7);
    @(negedge clk);
    chk("d0100_total", total_shift, 7);

    tick();
    send(16'h0000, 32'h0000_0000);
    wait_lat();
    @(negedge clk);
    chk("dzero_lzc", out_lzc, 16);
    chk("dzero_norm", out_norm, 0);
    chk("dzero_zero", out_zero, 1);
    chk("dzero_lzc32", out_lzc_32, 32);
    @(negedge clk);
    chk("dzero_total", total_shift, 23);
    chk("dzero_total_sat", total_shift_s, 15);

    tick();
    send(16'h8000, 32'h0000_8000);
    wait_lat();
    @(negedge clk);
    chk("d8000_lzc", out_lzc, 0);
    chk("d8000_norm", out_norm, 16'h8000);
    chk("d8000_lzc32", out_lzc_32, 16);
    chk("d8000_norm32", out_norm_32, 32'h8000_0000);

    tick();
    send(16'h1000, 32'h1000_0000);
    wait_lat();
    clr_total = 1'b1;
    tick();
    clr_total = 1'b0;
    @(negedge clk);
    chk("clr_add_total", total_shift, 3);
    chk("clr_add_total_sat", total_shift_s, 3);
    chk("clr_add_total32", total_shift_32, 3);

    tick();
    out_ready = 1'b0;
    send(16'h0003, 32'h0000_0003);
    in_valid = 1'b1; in_range16 = 16'h00F0; in_range32 = 32'h00F0_0000;
    wait_lat();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_lzc", out_lzc, 14);
      chk("hold_norm", out_norm, 16'hC000);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("hold_release_accept", got, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 70);
      clr_total = ($urandom_range(0, 99) < 2);
      t16 = 16'($urandom);
      t32 = $urandom;
      in_range16 = ($urandom_range(0, 15) == 0) ? 16'd0 : t16 >> $urandom_range(0, 16);
      in_range32 = ($urandom_range(0, 15) == 0) ? 32'd0 : t32 >> $urandom_range(0, 32);
      tick();
    end
    in_valid = 1'b0; clr_total = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    out_ready = 1'b0;
    in_valid = 1'b1; in_range16 = 16'h0010; in_range32 = 32'h0000_0010;
    repeat (3) tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_total", total_shift, 0);
    chk("midrst_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
